// File: rtl/mod_seq_gen.sv
// mod_seq_gen: segment-table frequency/amplitude sequencer feeding a DDS; define MOD_SEQ_AMP_SAT_EN for saturating amplitude
module mod_seq_gen #(
   parameter int BFREQ = 32,
   parameter int BAMP = 16,
   parameter int BT = 16,
   parameter int NSEG_LOG2 = 4,
   parameter int BLOOP = 8
) (
   input  logic aclk,
   input  logic areset,
   input  logic trigger,
   output logic trigger_out,
   input  logic s_axis_tvalid,
   output logic s_axis_tready,
   input  logic [31:0] s_axis_tdata,
   input  logic s_axis_tlast,
   input  logic ARM_REG,
   input  logic [1:0] MODE_REG,
   input  logic [BLOOP-1:0] NLOOP_REG,
   input  logic STOP_REG,
   output logic m_axis_tvalid,
   output logic [BFREQ+BAMP-1:0] m_axis_tdata,
   output logic busy,
   output logic [NSEG_LOG2-1:0] seg_idx
);
   localparam int NSEG = 2 ** NSEG_LOG2;
   localparam int AMAX = 2 ** BAMP - 1;
   localparam logic [NSEG_LOG2:0] SEG_MAX = {1'b1, {NSEG_LOG2{1'b0}}};
   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
   state_t state, nstate;
   logic [BFREQ-1:0] t_f [NSEG];
   logic [BFREQ-1:0] t_fs [NSEG];
   logic [BAMP-1:0] t_a [NSEG];
   logic [15:0] t_as [NSEG];
   logic [BT-1:0] t_d [NSEG];
   logic [BFREQ-1:0] n_f, n_fs, f_acc, f_step;
   logic [BAMP-1:0] n_a, a_acc;
   logic [15:0] n_as, a_step;
   logic [BT-1:0] n_d, rem;
   logic [NSEG_LOG2+2:0] wptr, wp1;
   logic [NSEG_LOG2:0] seg_cnt;
   logic [NSEG_LOG2-1:0] nidx, succ, rd_idx;
   logic [1:0] mode_r;
   logic [BLOOP-1:0] nloop, lcnt;
   logic trig_s1, trig_s2, trig_s3, arm_d;
   logic wr_en, arm_rise, trig_rise, seg_end, tab_end, pass_done, load;

   function automatic logic [BAMP-1:0] amp_add(input logic [BAMP-1:0] a, input logic [15:0] s);
`ifdef MOD_SEQ_AMP_SAT_EN
      logic [17:0] sum;
      sum = 18'(a) + {{2{s[15]}}, s};
      return sum[17] ? '0 : (sum[16:0] > 17'(AMAX)) ? '1 : sum[BAMP-1:0];
`else
      return a + BAMP'(s);
`endif
   endfunction

   assign wr_en = s_axis_tvalid && s_axis_tready;
   assign wp1 = wptr + 1'b1;
   assign arm_rise = ARM_REG && !arm_d;
   assign trig_rise = trig_s2 && !trig_s3;
   assign seg_end = rem == '0;
   // nidx holds the segment waiting in the prefetch slot, so it wraps to 0 exactly when the current one is last
   assign succ = ({1'b0, nidx} + 1'b1 == seg_cnt) ? '0 : nidx + 1'b1;
   assign tab_end = seg_end && nidx == '0;
   assign pass_done = mode_r == 2'd1 ? 1'b0 : mode_r == 2'd2 ? ({1'b0, lcnt} + 1'b1 >= {1'b0, nloop}) : 1'b1;
   assign load = nstate == RUN && (state == ARMED || seg_end);
   assign rd_idx = load ? succ : nidx;

   // next state: stop wins, arming needs a loaded table, playback ends after the last pass
   always_comb
      nstate = STOP_REG ? IDLE :
               state == IDLE ? ((arm_rise && seg_cnt != '0) ? ARMED : IDLE) :
               state == ARMED ? (trig_rise ? RUN : ARMED) :
               (tab_end && pass_done) ? IDLE : RUN;

   // table RAM: word-wise writes from the config stream, registered read into the prefetch slot
   always_ff @(posedge aclk) begin
      if (wr_en && !wptr[NSEG_LOG2+2]) begin
         if (wptr[1:0] == 2'd0) t_f[wptr[NSEG_LOG2+1:2]] <= s_axis_tdata[BFREQ-1:0];
         if (wptr[1:0] == 2'd1) t_fs[wptr[NSEG_LOG2+1:2]] <= s_axis_tdata[BFREQ-1:0];
         if (wptr[1:0] == 2'd2) t_a[wptr[NSEG_LOG2+1:2]] <= s_axis_tdata[BAMP-1:0];
         if (wptr[1:0] == 2'd2) t_as[wptr[NSEG_LOG2+1:2]] <= s_axis_tdata[31:16];
         if (wptr[1:0] == 2'd3) t_d[wptr[NSEG_LOG2+1:2]] <= s_axis_tdata[BT-1:0];
      end
      n_f <= t_f[rd_idx];
      n_fs <= t_fs[rd_idx];
      n_a <= t_a[rd_idx];
      n_as <= t_as[rd_idx];
      n_d <= t_d[rd_idx];
   end

   // control: trigger sync, table pointer, loop accounting, gapless segment playback with registered outputs
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
         trig_s1 <= 1'b0;
         trig_s2 <= 1'b0;
         trig_s3 <= 1'b0;
         arm_d <= 1'b0;
         s_axis_tready <= 1'b0;
         busy <= 1'b0;
         wptr <= '0;
         seg_cnt <= '0;
         mode_r <= '0;
         nloop <= '0;
         lcnt <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata <= '0;
         trigger_out <= 1'b0;
         seg_idx <= '0;
         nidx <= '0;
         f_acc <= '0;
         f_step <= '0;
         a_acc <= '0;
         a_step <= '0;
         rem <= '0;
      end else begin
         trig_s1 <= trigger;
         trig_s2 <= trig_s1;
         trig_s3 <= trig_s2;
         arm_d <= ARM_REG;
         state <= nstate;
         s_axis_tready <= nstate == IDLE;
         busy <= nstate != IDLE;
         if (wr_en && s_axis_tlast) begin
            seg_cnt <= wptr[NSEG_LOG2+2] ? SEG_MAX : wp1[NSEG_LOG2+2:2];
            wptr <= '0;
         end else if (wr_en && !wptr[NSEG_LOG2+2]) wptr <= wp1;
         if (state == ARMED) begin
            mode_r <= MODE_REG;
            nloop <= NLOOP_REG == '0 ? BLOOP'(1) : NLOOP_REG;
            lcnt <= '0;
         end else if (load && tab_end) lcnt <= lcnt + 1'b1;
         if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= {n_a, n_f};
            trigger_out <= nidx == '0;
            seg_idx <= nidx;
            nidx <= succ;
            f_acc <= n_f + n_fs;
            f_step <= n_fs;
            a_acc <= amp_add(n_a, n_as);
            a_step <= n_as;
            rem <= n_d == '0 ? '0 : n_d - 1'b1;
         end else if (nstate == RUN) begin
            m_axis_tdata <= {a_acc, f_acc};
            trigger_out <= 1'b0;
            f_acc <= f_acc + f_step;
            a_acc <= amp_add(a_acc, a_step);
            rem <= rem - 1'b1;
         end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata <= '0;
            trigger_out <= 1'b0;
            seg_idx <= '0;
            nidx <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mod_seq_gen.sv
// tb_mod_seq_gen: randomized table playback checked against a sample-list model of mod_seq_gen
module tb_mod_seq_gen;
   logic aclk = 1'b0, areset = 1'b1, trigger = 1'b0, trigger_out;
   logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic ARM_REG = 1'b0, STOP_REG = 1'b0;
   logic [1:0] MODE_REG = '0;
   logic [7:0] NLOOP_REG = '0;
   logic m_axis_tvalid, busy;
   logic [47:0] m_axis_tdata;
   logic [3:0] seg_idx;

   typedef struct {
      logic [31:0] f;
      logic [15:0] a;
      int s;
      logic t;
   } smp_t;

   smp_t exp_q[$];
   smp_t ce;
   logic [31:0] words[$];
   int total = 0, bad = 0;
   bit started = 0;
   logic [15:0] sat_exp [3];
   logic [47:0] p1 [4];

   mod_seq_gen dut (
      .aclk(aclk), .areset(areset), .trigger(trigger), .trigger_out(trigger_out),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .ARM_REG(ARM_REG), .MODE_REG(MODE_REG), .NLOOP_REG(NLOOP_REG),
      .STOP_REG(STOP_REG), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .busy(busy), .seg_idx(seg_idx)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic int amp_next(int a, int st);
      int v;
      v = a + st;
`ifdef MOD_SEQ_AMP_SAT_EN
      return v < 0 ? 0 : (v > 65535 ? 65535 : v);
`else
      return v & 32'hFFFF;
`endif
   endfunction

   function automatic int nseg();
      return words.size() / 4 > 16 ? 16 : words.size() / 4;
   endfunction

   // expected sample list: every pass walks every complete segment, values stepped per sample
   function automatic void gen(int passes, int limit);
      exp_q.delete();
      for (int p = 0; p < passes; p++)
         for (int s = 0; s < nseg(); s++) begin
            logic [31:0] f, fs, w2, w3;
            int a, st, d;
            smp_t e;
            f = words[4*s];
            fs = words[4*s+1];
            w2 = words[4*s+2];
            w3 = words[4*s+3];
            a = int'(w2[15:0]);
            st = int'($signed(w2[31:16]));
            d = int'(w3[15:0]);
            if (d == 0) d = 1;
            for (int k = 0; k < d; k++) begin
               if (exp_q.size() >= limit) return;
               e.f = f;
               e.a = 16'(a);
               e.s = s;
               e.t = (s == 0 && k == 0);
               exp_q.push_back(e);
               f = f + fs;
               a = amp_next(a, st);
            end
         end
   endfunction

   task automatic add_seg(input logic [31:0] f, input logic [31:0] fs, input logic [31:0] a, input logic [31:0] as, input logic [31:0] d);
      words.push_back(f);
      words.push_back(fs);
      words.push_back({as[15:0], a[15:0]});
      words.push_back(d);
   endtask

   task automatic load();
      chk("tready_idle", s_axis_tready, 1);
      for (int i = 0; i < words.size(); i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata = words[i];
         s_axis_tlast = (i == words.size() - 1);
         @(negedge aclk);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
   endtask

   task automatic arm();
      ARM_REG = 1'b1;
      @(negedge aclk);
      ARM_REG = 1'b0;
      @(negedge aclk);
      chk("arm_busy", busy, 64'(nseg() > 0));
   endtask

   // one playback: arm, trigger, pin the start latency, optionally stop, wait for the list to drain
   task automatic run(input int mode, input int nloop, input int stop_after);
      int budget;
      MODE_REG = 2'(mode);
      NLOOP_REG = 8'(nloop);
      arm();
      trigger = 1'b1;
      @(negedge aclk);
      chk("lat_a", m_axis_tvalid, 0);
      @(negedge aclk);
      chk("lat_b", m_axis_tvalid, 0);
      @(negedge aclk);
      chk("lat_first", m_axis_tvalid, 1);
      chk("tready_run", s_axis_tready, 0);
      trigger = 1'b0;
      if (stop_after > 0) begin
         for (int i = 0; i < stop_after - 1; i++) begin
            if (i < stop_after - 5) begin
               s_axis_tvalid = 1'($urandom);
               s_axis_tdata = $urandom;
               s_axis_tlast = 1'($urandom);
               ARM_REG = 1'($urandom);
               trigger = 1'($urandom);
            end else begin
               s_axis_tvalid = 1'b0;
               s_axis_tlast = 1'b0;
               ARM_REG = 1'b0;
               trigger = 1'b0;
            end
            @(negedge aclk);
         end
         STOP_REG = 1'b1;
         @(negedge aclk);
         STOP_REG = 1'b0;
      end
      budget = 5000;
      while ((exp_q.size() > 0 || started) && budget > 0) begin
         @(negedge aclk);
         budget--;
      end
      chk("run_drained", exp_q.size(), 0);
      exp_q.delete();
      started = 0;
      repeat (2) @(negedge aclk);
   endtask

   // compare process: once the first sample shows, every cycle must match the list, then go quiet
   always @(negedge aclk) begin
      if (!started && exp_q.size() > 0 && m_axis_tvalid) started = 1;
      if (started) begin
         if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("tvalid", m_axis_tvalid, 1);
            chk("tdata", m_axis_tdata, {ce.a, ce.f});
            chk("seg_idx", seg_idx, 64'(ce.s));
            chk("trigger_out", trigger_out, ce.t);
         end else begin
            chk("end_tvalid", m_axis_tvalid, 0);
            chk("end_tdata", m_axis_tdata, 0);
            chk("end_busy", busy, 0);
            started = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge aclk);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_trigger_out", trigger_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_seg_idx", seg_idx, 0);
      chk("rst_tready", s_axis_tready, 0);
      areset = 1'b0;
      @(negedge aclk);
      arm();
      add_seg(1000, 10, 100, 1, 4);
      load();
      trigger = 1'b1;
      repeat (5) @(negedge aclk);
      chk("trig_idle_tvalid", m_axis_tvalid, 0);
      chk("trig_idle_busy", busy, 0);
      trigger = 1'b0;
      repeat (3) @(negedge aclk);
      p1 = '{{16'd100, 32'd1000}, {16'd101, 32'd1010}, {16'd102, 32'd1020}, {16'd103, 32'd1030}};
      gen(1, 1 << 30);
      chk("pin1_len", exp_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("pin1_smp", {exp_q[i].a, exp_q[i].f}, p1[i]);
      run(0, 0, 0);
      words.delete();
      add_seg(50, 1, 10, 0, 3);
      add_seg(900, 32'hFFFF_FFFF, 20, 16'hFFFF, 2);
      load();
      gen(1000, 12);
      chk("pin2_s3", exp_q[3].s, 1);
      chk("pin2_s5", exp_q[5].s, 0);
      chk("pin2_t5", exp_q[5].t, 1);
      chk("pin2_t1", exp_q[1].t, 0);
      run(1, 0, 12);
      words.delete();
      add_seg(7, 3, 500, 5, 3);
      add_seg(32'hFFFF_FFFE, 5, 9, 1, 1);
      load();
      gen(3, 1 << 30);
      chk("pin3_len", exp_q.size(), 12);
      run(2, 3, 0);
      words.delete();
      add_seg(1, 1, 32'hFFFE, 2, 3);
      load();
`ifdef MOD_SEQ_AMP_SAT_EN
      sat_exp = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
`else
      sat_exp = '{16'hFFFE, 16'h0000, 16'h0002};
`endif
      gen(1, 1 << 30);
      for (int i = 0; i < 3; i++) chk("pin4_amp", exp_q[i].a, sat_exp[i]);
      run(0, 0, 0);
      words.delete();
      add_seg(40, 2, 8, 1, 0);
      add_seg(60, 2, 8, 1, 2);
      load();
      gen(1, 1 << 30);
      chk("pin5_len", exp_q.size(), 3);
      run(3, 0, 0);
      words.delete();
      for (int i = 0; i < 17; i++) add_seg(i * 100, 1, i, 1, 1);
      load();
      gen(1, 1 << 30);
      chk("pin6_len", exp_q.size(), 16);
      run(0, 0, 0);
      for (int it = 0; it < 24; it++) begin
         int ns, md, nl, sa, passes;
         ns = 1 + $urandom % 5;
         words.delete();
         for (int s = 0; s < ns; s++)
            add_seg($urandom, $urandom,
                    ($urandom % 3 == 0) ? 32'hFFF0 + $urandom % 16 : ($urandom % 2 == 0) ? $urandom % 16 : $urandom,
                    $urandom, $urandom % 5);
         repeat ($urandom % 4) words.push_back($urandom);
         load();
         md = $urandom % 4;
         nl = $urandom % 4;
         sa = (md == 1) ? 3 + $urandom % 18 : 0;
         passes = md == 2 ? (nl == 0 ? 1 : nl) : md == 1 ? 1000 : 1;
         gen(passes, md == 1 ? sa : 1 << 30);
         run(md, nl, sa);
         if (md == 1) begin
            gen(1, 1 << 30);
            run(0, 0, 0);
         end
      end
      words.delete();
      add_seg(5, 3, 7, 1, 40);
      load();
      MODE_REG = 2'd1;
      arm();
      trigger = 1'b1;
      repeat (6) @(negedge aclk);
      chk("mid_tvalid", m_axis_tvalid, 1);
      #2 areset = 1'b1;
      #1;
      chk("arst_tvalid", m_axis_tvalid, 0);
      chk("arst_tdata", m_axis_tdata, 0);
      chk("arst_trigger_out", trigger_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_seg_idx", seg_idx, 0);
      @(negedge aclk);
      areset = 1'b0;
      trigger = 1'b0;
      repeat (4) @(negedge aclk);
      words.delete();
      arm();
      repeat (2) @(negedge aclk);
      chk("arst_no_arm", busy, 0);
      add_seg(1000, 10, 100, 1, 4);
      load();
      gen(1, 1 << 30);
      run(0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
